picorv32_pcpi_div_iter: RTL

//  PCPI co-processor for RV32M/RV64M DIV/DIVU/REM/REMU. Iterative restoring divider, STEPS quotient bits per cycle.

---
 rtl/picorv32_pcpi_div_iter_pkg.sv | 40 ++++
 rtl/picorv32_pcpi_div_iter_if.sv | 23 ++
 rtl/picorv32_pcpi_div_iter_step.sv | 25 ++
 rtl/picorv32_pcpi_div_iter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_pcpi_div_iter_pkg.sv
// Shared types and decode constants for the iterative PCPI divider.
package picorv32_div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_INIT = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;
  localparam logic [2:0] F3_DIV     = 3'b100;
  localparam logic [2:0] F3_DIVU    = 3'b101;
  localparam logic [2:0] F3_REM     = 3'b110;
  localparam logic [2:0] F3_REMU    = 3'b111;

  function automatic logic is_div_funct3(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  function automatic div_op_t op_from_funct3(input logic [2:0] f3);
    div_op_t op;
    case (f3)
      F3_DIV:  op = OP_DIV;
      F3_DIVU: op = OP_DIVU;
      F3_REM:  op = OP_REM;
      default: op = OP_REMU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/picorv32_pcpi_div_iter_if.sv
// PCPI bus between the core (master) and the divide co-processor (slave).
interface picorv32_pcpi_div_iter_if #(
  parameter int unsigned XLEN = 32
);
  logic            pcpi_valid;
  logic [31:0]     pcpi_insn;
  logic [XLEN-1:0] pcpi_rs1;
  logic [XLEN-1:0] pcpi_rs2;
  logic            pcpi_wr;
  logic [XLEN-1:0] pcpi_rd;
  logic            pcpi_wait;
  logic            pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );
endinterface

// File: rtl/picorv32_pcpi_div_iter_step.sv
// One combinational restoring-division step; chained to resolve several quotient bits per cycle.
module picorv32_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]   dividend_i,
  input  logic [2*XLEN-2:0] divisor_i,
  input  logic [XLEN-1:0]   mask_i,
  input  logic [XLEN-1:0]   quotient_i,
  output logic [XLEN-1:0]   dividend_c,
  output logic [2*XLEN-2:0] divisor_c,
  output logic [XLEN-1:0]   mask_c,
  output logic [XLEN-1:0]   quotient_c
);
  localparam int unsigned DW = 2 * XLEN - 1;

  logic take_c;

  // When the subtract is taken the divisor fits in XLEN bits, so its low slice is exact.
  assign take_c     = divisor_i <= DW'(dividend_i);
  assign dividend_c = take_c ? (dividend_i - divisor_i[XLEN-1:0]) : dividend_i;
  assign quotient_c = take_c ? (quotient_i | mask_i) : quotient_i;
  assign divisor_c  = divisor_i >> 1;
  assign mask_c     = mask_i >> 1;

endmodule

// File: rtl/picorv32_pcpi_div_iter.sv
// Iterative RV32M/RV64M DIV/DIVU/REM/REMU co-processor on the PCPI bus, STEPS quotient bits per cycle.
module picorv32_pcpi_div_iter
  import picorv32_div_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned STEPS = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  picorv32_pcpi_div_iter_if.slave     pcpi
);
  localparam int unsigned N     = XLEN / STEPS;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned DW    = 2 * XLEN - 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, (XLEN-1)'(0)};

  if (!((XLEN == 32 || XLEN == 64) &&
        (STEPS == 1 || STEPS == 2 || STEPS == 4 || STEPS == 8) &&
        (XLEN % STEPS == 0))) begin : g_bad_cfg
    $error("picorv32_pcpi_div_iter: unsupported XLEN/STEPS combination");
  end

  state_t            state_q, state_d;
  div_op_t           op_q, op_d;
  logic [XLEN-1:0]   rs1_q, rs1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0]   dividend_q, dividend_d;
  logic [DW-1:0]     divisor_q, divisor_d;
  logic [XLEN-1:0]   mask_q, mask_d;
  logic [XLEN-1:0]   quotient_q, quotient_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              outsign_q, outsign_d;
  logic              wr_q, wr_d;
  logic [XLEN-1:0]   rd_q, rd_d;
  logic              wait_q, wait_d;
  logic              ready_q, ready_d;

  // Instruction decode; register/immediate fields are irrelevant here.
  logic [6:0] opcode_c;
  logic [6:0] funct7_c;
  logic [2:0] funct3_c;
  logic       dec_hit_c;
  logic       unused_insn_c;

  assign opcode_c      = pcpi.pcpi_insn[6:0];
  assign funct3_c      = pcpi.pcpi_insn[14:12];
  assign funct7_c      = pcpi.pcpi_insn[31:25];
  assign dec_hit_c     = (opcode_c == OPC_OP) && (funct7_c == F7_MULDIV) && is_div_funct3(funct3_c);
  assign unused_insn_c = ^{pcpi.pcpi_insn[24:15], pcpi.pcpi_insn[11:7]};

  // Operand classification on the latched operands.
  logic            is_signed_c;
  logic            is_rem_c;
  logic            rs1_neg_c;
  logic            rs2_neg_c;
  logic [XLEN-1:0] abs1_c;
  logic [XLEN-1:0] abs2_c;
  logic            div_zero_c;
  logic            overflow_c;

  assign is_signed_c = (op_q == OP_DIV) || (op_q == OP_REM);
  assign is_rem_c    = (op_q == OP_REM) || (op_q == OP_REMU);
  assign rs1_neg_c   = is_signed_c && rs1_q[XLEN-1];
  assign rs2_neg_c   = is_signed_c && rs2_q[XLEN-1];
  assign abs1_c      = rs1_neg_c ? (-rs1_q) : rs1_q;
  assign abs2_c      = rs2_neg_c ? (-rs2_q) : rs2_q;
  assign div_zero_c  = (rs2_q == '0);
  assign overflow_c  = is_signed_c && (rs1_q == MIN_INT) && (rs2_q == '1);

  // Chain of STEPS restoring steps evaluated in one cycle.
  logic [XLEN-1:0] ch_dvd [STEPS+1];
  logic [DW-1:0]   ch_dvs [STEPS+1];
  logic [XLEN-1:0] ch_msk [STEPS+1];
  logic [XLEN-1:0] ch_quo [STEPS+1];

  assign ch_dvd[0] = dividend_q;
  assign ch_dvs[0] = divisor_q;
  assign ch_msk[0] = mask_q;
  assign ch_quo[0] = quotient_q;

  for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
    picorv32_div_step #(.XLEN(XLEN)) u_step (
      .dividend_i (ch_dvd[gi]),
      .divisor_i  (ch_dvs[gi]),
      .mask_i     (ch_msk[gi]),
      .quotient_i (ch_quo[gi]),
      .dividend_c (ch_dvd[gi+1]),
      .divisor_c  (ch_dvs[gi+1]),
      .mask_c     (ch_msk[gi+1]),
      .quotient_c (ch_quo[gi+1])
    );
  end

  logic [XLEN-1:0] quot_fin_c;
  logic [XLEN-1:0] rem_fin_c;
  logic [XLEN-1:0] result_c;

  assign quot_fin_c = ch_quo[STEPS];
  assign rem_fin_c  = ch_dvd[STEPS];
  assign result_c   = is_rem_c ? (outsign_q ? (-rem_fin_c)  : rem_fin_c)
                               : (outsign_q ? (-quot_fin_c) : quot_fin_c);

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    mask_d     = mask_q;
    quotient_d = quotient_q;
    cnt_d      = cnt_q;
    outsign_d  = outsign_q;
    wr_d       = 1'b0;
    rd_d       = '0;
    wait_d     = wait_q;
    ready_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        wait_d = 1'b0;
        if (pcpi.pcpi_valid && dec_hit_c && !ready_q) begin
          op_d    = op_from_funct3(funct3_c);
          rs1_d   = pcpi.pcpi_rs1;
          rs2_d   = pcpi.pcpi_rs2;
          wait_d  = 1'b1;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        if (!pcpi.pcpi_valid) begin
          wait_d  = 1'b0;
          state_d = S_IDLE;
        end else if (div_zero_c || overflow_c) begin
          wait_d  = 1'b0;
          ready_d = 1'b1;
          wr_d    = 1'b1;
          state_d = S_DONE;
          if (div_zero_c) rd_d = is_rem_c ? rs1_q : '1;
          else            rd_d = is_rem_c ? '0    : MIN_INT;
        end else begin
          dividend_d = abs1_c;
          divisor_d  = {abs2_c, (XLEN-1)'(0)};
          mask_d     = MIN_INT;
          quotient_d = '0;
          cnt_d      = CNT_W'(N);
          outsign_d  = (op_q == OP_DIV) ? (rs1_neg_c ^ rs2_neg_c) :
                       (op_q == OP_REM) ? rs1_neg_c : 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (!pcpi.pcpi_valid) begin
          wait_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          dividend_d = ch_dvd[STEPS];
          divisor_d  = ch_dvs[STEPS];
          mask_d     = ch_msk[STEPS];
          quotient_d = ch_quo[STEPS];
          cnt_d      = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            wait_d  = 1'b0;
            ready_d = 1'b1;
            wr_d    = 1'b1;
            rd_d    = result_c;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        wait_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        wait_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_DIV;
      rs1_q      <= '0;
      rs2_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      mask_q     <= '0;
      quotient_q <= '0;
      cnt_q      <= '0;
      outsign_q  <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= '0;
      wait_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      mask_q     <= mask_d;
      quotient_q <= quotient_d;
      cnt_q      <= cnt_d;
      outsign_q  <= outsign_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      wait_q     <= wait_d;
      ready_q    <= ready_d;
    end
  end

  assign pcpi.pcpi_wr    = wr_q;
  assign pcpi.pcpi_rd    = rd_q;
  assign pcpi.pcpi_wait  = wait_q;
  assign pcpi.pcpi_ready = ready_q;

endmodule
